// File: rtl/fuse_key_loader.sv
// Fuse key loader: reads a contiguous run of 32-bit fuse words and assembles
// them into one wide key register, reporting done/error and holding the key.
module fuse_key_loader #(
  parameter int MAX_WORDS = 8,
  parameter int FUSE_SIZE = 100,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [CW-1:0]           num_words_i,
  input  logic                    clear_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    key_valid_o,
  output logic [MAX_WORDS*32-1:0] key_o,
  output logic                    fuse_req_o,
  output logic [31:0]             fuse_addr_o,
  input  logic [31:0]             fuse_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [CW-1:0]           num_q, num_d;
  logic [CW-1:0]           req_cnt_q, req_cnt_d;
  logic                    cap_valid_q, cap_valid_d;
  logic [CW-1:0]           cap_idx_q, cap_idx_d;
  logic [MAX_WORDS*32-1:0] key_q, key_d;
  logic                    key_valid_q, key_valid_d;
  logic                    err_q, err_d;

  logic [32:0]             end_addr;
  logic                    range_err;
  logic                    req_active;
  logic                    last_capture;

  // End address is formed at 33 bits so a huge base cannot wrap into range.
  assign end_addr  = {1'b0, base_addr_i} + {{(33-CW){1'b0}}, num_words_i};
  assign range_err = (num_words_i == '0) ||
                     (num_words_i > CW'(MAX_WORDS)) ||
                     (end_addr > 33'(FUSE_SIZE));

  assign req_active   = (state_q == READ) && (req_cnt_q < num_q);
  assign last_capture = cap_valid_q && (cap_idx_q == num_q - CW'(1));

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign key_valid_o = key_valid_q;
  assign key_o       = key_q;
  assign fuse_req_o  = req_active;
  assign fuse_addr_o = req_active ? (base_q + {{(32-CW){1'b0}}, req_cnt_q}) : 32'd0;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    req_cnt_d   = req_cnt_q;
    cap_valid_d = req_active;
    cap_idx_d   = req_cnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d      = base_addr_i;
          num_d       = num_words_i;
          req_cnt_d   = '0;
          key_d       = '0;
          key_valid_d = 1'b0;
          err_d       = range_err;
          state_d     = range_err ? DONE : READ;
        end
      end
      READ: begin
        if (req_active) begin
          req_cnt_d = req_cnt_q + CW'(1);
        end
        // Read data arrives one cycle after its request, tagged by cap_idx_q.
        for (int j = 0; j < MAX_WORDS; j++) begin
          if (cap_valid_q && (cap_idx_q == CW'(j))) begin
            key_d[32*j +: 32] = fuse_rdata_i;
          end
        end
        if (last_capture) begin
          key_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear overrides everything, including a start in the same cycle.
    if (clear_i) begin
      state_d     = IDLE;
      req_cnt_d   = '0;
      cap_valid_d = 1'b0;
      key_d       = '0;
      key_valid_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      req_cnt_q   <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      req_cnt_q   <= req_cnt_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_fuse_key_loader.sv
// Directed bench for fuse_key_loader: table of loads plus hand-written
// sequences for ignored start, clear and asynchronous reset mid-load.
module tb_fuse_key_loader;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [3:0]   num_words;
  logic         clear;
  logic         busy;
  logic         done;
  logic         err;
  logic         key_valid;
  logic [255:0] key;
  logic         fuse_req;
  logic [31:0]  fuse_addr;
  logic [31:0]  fuse_rdata;

  int checks;
  int errors;
  int done_cyc;
  bit req_ok;
  bit accept_ok;
  bit addr_bad;

  typedef struct {
    logic [31:0] base;
    logic [3:0]  num;
    int          poke;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs[10];

  fuse_key_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .num_words_i (num_words),
    .clear_i     (clear),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .key_valid_o (key_valid),
    .key_o       (key),
    .fuse_req_o  (fuse_req),
    .fuse_addr_o (fuse_addr),
    .fuse_rdata_i(fuse_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fuse memory model; junk data when no request makes mistimed captures visible.
  always @(posedge clk) begin
    fuse_rdata <= fuse_req ? (32'hA500_0000 | fuse_addr) : 32'hDEAD_BEEF;
    if (fuse_req && (fuse_addr >= 32'd100)) addr_bad = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] expKey(input logic [31:0] base, input logic [3:0] num);
    logic [255:0] k;
    k = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < int'(num)) k[32*j +: 32] = 32'hA500_0000 | (base + 32'(j));
    end
    return k;
  endfunction

  // Issues a start in the current cycle and follows the load up to done_o.
  task automatic applyStimulus(input logic [31:0] base, input logic [3:0] num,
                               input bit exp_err, input int poke);
    int  cyc;
    bit  exp_req;
    logic [31:0] exp_addr;
    base_addr = base;
    num_words = num;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    done_cyc  = -1;
    req_ok    = 1'b1;
    accept_ok = (key_valid == 1'b0) && (busy == 1'b1) && (key == '0);
    cyc = 1;
    while (cyc < 40) begin
      exp_req  = !exp_err && (cyc <= int'(num));
      exp_addr = exp_req ? (base + 32'(cyc - 1)) : 32'd0;
      if ((fuse_req !== exp_req) || (fuse_addr !== exp_addr)) req_ok = 1'b0;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (poke != 0 && cyc == poke) begin
        start     = 1'b1;
        base_addr = 32'd0;
        num_words = 4'd2;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    bit quiet;
    checks    = 0;
    errors    = 0;
    addr_bad  = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    clear     = 1'b0;
    base_addr = 32'd0;
    num_words = 4'd0;

    vecs[0] = '{base: 32'd0,          num: 4'd6, poke: 0, exp_err: 1'b0, exp_done: 8};
    vecs[1] = '{base: 32'd96,         num: 4'd6, poke: 0, exp_err: 1'b1, exp_done: 1};
    vecs[2] = '{base: 32'd96,         num: 4'd0, poke: 0, exp_err: 1'b1, exp_done: 1};
    vecs[3] = '{base: 32'd96,         num: 4'd9, poke: 0, exp_err: 1'b1, exp_done: 1};
    vecs[4] = '{base: 32'd92,         num: 4'd8, poke: 3, exp_err: 1'b0, exp_done: 10};
    vecs[5] = '{base: 32'd8,          num: 4'd4, poke: 0, exp_err: 1'b0, exp_done: 6};
    vecs[6] = '{base: 32'd93,         num: 4'd8, poke: 0, exp_err: 1'b1, exp_done: 1};
    vecs[7] = '{base: 32'd99,         num: 4'd1, poke: 0, exp_err: 1'b0, exp_done: 3};
    vecs[8] = '{base: 32'hFFFF_FFFF,  num: 4'd1, poke: 0, exp_err: 1'b1, exp_done: 1};
    vecs[9] = '{base: 32'd16,         num: 4'd2, poke: 0, exp_err: 1'b0, exp_done: 4};

    #1;
    checkOutput("rst_busy",  busy, 0);
    checkOutput("rst_done",  done, 0);
    checkOutput("rst_err",   err, 0);
    checkOutput("rst_kv",    key_valid, 0);
    checkOutput("rst_key",   key, 0);
    checkOutput("rst_req",   fuse_req, 0);
    checkOutput("rst_addr",  fuse_addr, 0);
    tick();
    #2 rst = 1'b0;
    tick();

    // Back-to-back loads: each new start lands in the cycle after done_o.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].base, vecs[i].num, vecs[i].exp_err, vecs[i].poke);
      checkOutput($sformatf("v%0d_done_cycle", i), 256'(done_cyc), 256'(vecs[i].exp_done));
      checkOutput($sformatf("v%0d_accept", i), accept_ok, 1);
      checkOutput($sformatf("v%0d_req_trace", i), req_ok, 1);
      checkOutput($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      checkOutput($sformatf("v%0d_kv", i), key_valid, !vecs[i].exp_err);
      checkOutput($sformatf("v%0d_key", i), key,
                  vecs[i].exp_err ? 256'd0 : expKey(vecs[i].base, vecs[i].num));
      checkOutput($sformatf("v%0d_busy", i), busy, 1);
      tick();
      checkOutput($sformatf("v%0d_idle_done", i), done, 0);
      checkOutput($sformatf("v%0d_idle_busy", i), busy, 0);
      checkOutput($sformatf("v%0d_idle_err", i), err, vecs[i].exp_err);
      checkOutput($sformatf("v%0d_idle_kv", i), key_valid, !vecs[i].exp_err);
    end

    // Clear in IDLE zeroizes a held key.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_idle_kv",  key_valid, 0);
    checkOutput("clr_idle_key", key, 0);

    // Clear in cycle 4 of an 8-word load.
    base_addr = 32'd0;
    num_words = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("clr_pre_req", fuse_req, 1);
    checkOutput("clr_pre_key_nonzero", (key != '0), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_req",  fuse_req, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_done", done, 0);
    checkOutput("clr_key",  key, 0);
    checkOutput("clr_kv",   key_valid, 0);
    checkOutput("clr_err",  err, 0);
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done !== 1'b0 || fuse_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      tick();
    end
    checkOutput("clr_quiet_after", quiet, 1);

    // Clear and start together: clear wins.
    base_addr = 32'd0;
    num_words = 4'd2;
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    checkOutput("clr_start_busy", busy, 0);
    checkOutput("clr_start_req",  fuse_req, 0);
    tick();
    checkOutput("clr_start_busy2", busy, 0);

    // Asynchronous reset mid-load with a partial key captured.
    base_addr = 32'd0;
    num_words = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("mid_pre_key_nonzero", (key != '0), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_req",  fuse_req, 0);
    checkOutput("mid_rst_addr", fuse_addr, 0);
    checkOutput("mid_rst_key",  key, 0);
    checkOutput("mid_rst_kv",   key_valid, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_err",  err, 0);
    #2 rst = 1'b0;
    tick();
    applyStimulus(32'd16, 4'd2, 1'b0, 0);
    checkOutput("post_rst_done_cycle", 256'(done_cyc), 256'(4));
    checkOutput("post_rst_req_trace", req_ok, 1);
    checkOutput("post_rst_kv",  key_valid, 1);
    checkOutput("post_rst_key", key, {192'd0, 32'hA500_0011, 32'hA500_0010});
    tick();

    checkOutput("fuse_addr_in_range", addr_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fuse_key_loader.md
Name: fuse_key_loader

Overview:
- Sequencer that reads a contiguous run of 32-bit fuse words through the fuse memory read port and assembles them into one wide key register for a crypto/debug consumer (AES, SHA, HMAC key inputs).
- Sits directly downstream of the fuse memory. It drives that memory's req/addr port and consumes its rdata, which is valid in the cycle after the request.
- Software or boot logic supplies a base word address and a word count. The block reports done or error, and holds the key until cleared.

Parameters:
- MAX_WORDS, 8, maximum words per load; key_o width is MAX_WORDS*32.
- FUSE_SIZE, 100, number of valid fuse word addresses (0..FUSE_SIZE-1).
- CW, $clog2(MAX_WORDS+1), width of the word-count fields.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  load request; sampled only when busy_o=0.
- base_addr_i  in  32  fuse word address of the key LSB word.
- num_words_i  in  CW  number of words to load.
- clear_i  in  1  zeroize key and abort any load.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse at load completion (success or error).
- err_o  out  1  last start was rejected; sticky until the next accepted start, clear_i or reset.
- key_valid_o  out  1  key_o holds a complete loaded key.
- key_o  out  MAX_WORDS*32  assembled key.
- fuse_req_o  out  1  fuse read request.
- fuse_addr_o  out  32  fuse word address.
- fuse_rdata_i  in  32  fuse read data, valid the cycle after the request.

Behaviour:
- Reset: all outputs 0, key_o all zero, FSM in IDLE.
- States are IDLE, READ and DONE.
- IDLE, start_i=1, clear_i=0 (cycle 0), checks:
  - Latch base and count; zero key_o; drop key_valid_o and err_o.
  - Range check: error if num_words_i==0, num_words_i>MAX_WORDS, or base+num>FUSE_SIZE. The sum is computed at 33 bits so there is no wrap.
  - On error: go to DONE; no fuse_req_o is ever issued; err_o=1.
  - Otherwise: go to READ.
- READ, request side: in cycle k (k=1..N), fuse_req_o=1 and fuse_addr_o=base+k-1. Once all N requests are issued, fuse_req_o=0 and fuse_addr_o=0.
- READ, capture side:
  - A registered capture flag/index follows each request by one cycle.
  - Word j (address base+j) is captured from fuse_rdata_i at the end of cycle j+2 into key_o[32*j +: 32].
  - Words j>=N stay zero.
- READ to DONE: after the final capture (end of cycle N+1), go to DONE.
- DONE, one cycle:
  - done_o=1.
  - key_valid_o set at the same edge as done_o on success, and held until clear_i, reset or the next accepted start.
  - Then return to IDLE.
- Timing:
  - Success: done_o in cycle N+2.
  - Error: done_o in cycle 1.
- busy_o=1 exactly when the state is READ or DONE. A new start is accepted in the cycle after done_o.
- start_i while busy_o=1 is ignored: no queuing, no effect on the current load.
- clear_i, any state:
  - Next edge: key_o=0, key_valid_o=0, err_o=0, FSM to IDLE, fuse_req_o=0, no done_o pulse.
  - clear_i beats start_i when both are high in the same cycle.
- fuse_addr_o is never driven outside 0..FUSE_SIZE-1 while fuse_req_o=1.
- Asynchronous reset mid-load: immediate return to reset values; the partial key is discarded.

Test Plan:
- Fuse model returns 32'hA500_0000|addr. start, base=0, num=6 → fuse_req_o high cycles 1-6 with addr 0..5; done_o in cycle 8; key_o[191:0]={A5000005,…,A5000000}; key_o[255:192]=0; key_valid_o=1; err_o=0.
- Error start:
  - base=96, num=6 → done_o+err_o in cycle 1, fuse_req_o never asserted, key_valid_o=0, key_o=0.
  - Repeat with num=0 and with num=9: same response.
- Two loads and ignored start:
  - Load base=92, num=8 (addr 92..99 legal, upper bound exact); pulse start_i again during cycle 3 with base=0 → ignored.
  - Full key = words 92..99.
  - Immediate restart in the cycle after done_o, base=8, num=4 → key_valid_o drops, new key={A500000B..A5000008}, upper words zero.
- Clear and start together: assert clear_i in cycle 4 of an 8-word load → fuse_req_o low from cycle 5, no done_o, key_o=0, busy_o=0. Then clear_i and start_i high together → start not accepted.
- Reset mid-load: rst_i asserted mid-load → outputs zero with no clock edge needed; after deassert, a normal load base=16, num=2 completes with done_o in cycle 4.
